// File: rtl/sevenseg_scan_ctrl_if.sv
// Valid/ready write port carrying digit updates from the datapath into the
// scan controller's shadow registers.
interface sevenseg_scan_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_digit;
  logic [4:0] wr_data;   // [3:0] hex value, [4] decimal point

  modport master (output wr_valid, output wr_digit, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_digit, input wr_data, output wr_ready);
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with anti-ghosting
// blank time, shadow/active digit registers and tear-free frame commit.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE_W   = 17,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 lz_blank_en,
  sevenseg_scan_ctrl_if.slave  wr,
  output logic [7:0]           an,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [2:0]           cur_digit,
  output logic                 frame_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  localparam int                    BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0]         BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [2:0]            LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [PRESCALE_W-1:0] PS_MAX     = '1;
  localparam logic                  INV        = (ACTIVE_LOW != 0);

  logic [1:0]            state, nxt_state;
  logic [2:0]            idx, nxt_idx;
  logic [PRESCALE_W-1:0] prescaler, nxt_prescaler;
  logic [BW-1:0]         blank_cnt, nxt_blank_cnt;
  logic                  commit, nxt_commit;
  logic                  ready_q;

  logic [4:0] shadow     [8];
  logic [4:0] active     [8];
  logic [4:0] nxt_active [8];

  logic [7:0] lz_mask;
  logic       zero_run;
  logic [4:0] cur_val;
  logic [7:0] an_hi;
  logic [6:0] seg_hi;
  logic       dp_hi;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    nxt_state = state;
    nxt_idx   = idx;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        nxt_idx = 3'd0;
        if (en) nxt_state = BLANK;
      end
      BLANK: begin
        if (blank_cnt == BLANK_LAST) nxt_state = DRIVE;
      end
      DRIVE: begin
        if (prescaler == PS_MAX) begin
          nxt_state = BLANK;
          commit    = (idx == LAST_IDX);
          nxt_idx   = commit ? 3'd0 : idx + 3'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase
    // Disable wins over everything except a commit already due this cycle.
    if (!en) begin
      nxt_state = IDLE;
      nxt_idx   = 3'd0;
    end

    nxt_prescaler = (state == DRIVE && nxt_state == DRIVE) ? prescaler + 1'b1 : '0;
    nxt_blank_cnt = (state == BLANK && nxt_state == BLANK) ? blank_cnt + 1'b1 : '0;
    nxt_commit    = (nxt_state == DRIVE) && (nxt_prescaler == PS_MAX) && (nxt_idx == LAST_IDX);

    for (int i = 0; i < 8; i++) begin
      nxt_active[i] = commit ? shadow[i] : active[i];
    end

    // A digit blanks only when it and every digit above it hold zero with dp off.
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = 7; i >= 1; i--) begin
      if (i < NUM_DIGITS) begin
        zero_run   = zero_run && (nxt_active[i] == 5'd0);
        lz_mask[i] = zero_run && lz_blank_en;
      end
    end

    cur_val = nxt_active[nxt_idx];
    an_hi   = (nxt_state == DRIVE) ? (8'd1 << nxt_idx) : 8'd0;
    seg_hi  = (nxt_state == DRIVE && !lz_mask[nxt_idx]) ? hex_to_seg(cur_val[3:0]) : 7'd0;
    dp_hi   = (nxt_state == DRIVE && !lz_mask[nxt_idx]) ? cur_val[4] : 1'b0;
  end

  assign wr.wr_ready = ready_q;

  // NOTE: state updates use <= so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      prescaler  <= '0;
      blank_cnt  <= '0;
      ready_q    <= 1'b0;
      an         <= {8{INV}};
      seg        <= {7{INV}};
      dp         <= INV;
      cur_digit  <= 3'd0;
      frame_done <= 1'b0;
      // NOTE: digit storage is cleared explicitly; a freshly reset display must show zeros, not stale data.
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 5'd0;
        active[i] <= 5'd0;
      end
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      prescaler  <= nxt_prescaler;
      blank_cnt  <= nxt_blank_cnt;
      ready_q    <= !nxt_commit;
      an         <= an_hi ^ {8{INV}};
      seg        <= seg_hi ^ {7{INV}};
      dp         <= dp_hi ^ INV;
      cur_digit  <= (nxt_state == IDLE) ? 3'd0 : nxt_idx;
      frame_done <= commit;
      for (int i = 0; i < 8; i++) begin
        active[i] <= nxt_active[i];
      end
      // Out-of-range digit indices complete the handshake but store nothing.
      if (wr.wr_valid && ready_q && (int'(wr.wr_digit) < NUM_DIGITS)) begin
        shadow[wr.wr_digit] <= wr.wr_data;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: a frame-position reference model
// predicts every output cycle, a monitor compares at the falling edge.
module tb_sevenseg_scan_ctrl;

  localparam int NDIG  = 8;
  localparam int PW    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = BC + (1 << PW);   // cycles per digit slot
  localparam int FRAME = NDIG * SLOT;      // cycles per full scan

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       lz_blank_en = 1'b0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] cur_digit;
  logic       frame_done;

  sevenseg_scan_ctrl_if wr_if ();

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (NDIG),
    .PRESCALE_W  (PW),
    .BLANK_CYCLES(BC),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lz_blank_en(lz_blank_en),
    .wr         (wr_if),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .cur_digit  (cur_digit),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] cur;
    logic       fd;
    logic       rdy;
  } obs_t;

  obs_t       exp_q [$];
  logic [7:0] wr_q  [$];   // {digit, data} pending directed writes
  int         rand_pct = 0;
  int         n_vec = 0;
  int         n_bad = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: scan position is simply the cycle count since enable, modulo one frame.
  initial begin : model
    logic [4:0] m_shadow [NDIG];
    logic [4:0] m_active [NDIG];
    bit         running;
    bit         rdy;
    bit         commit;
    int         pos;
    int         dig;
    int         hi;
    obs_t       e;
    running = 0;
    rdy     = 0;
    pos     = 0;
    for (int i = 0; i < NDIG; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    forever begin
      @(posedge clk);
      e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, cur: 3'd0, fd: 1'b0, rdy: 1'b0};
      if (rst) begin
        running = 0;
        rdy     = 0;
        pos     = 0;
        for (int i = 0; i < NDIG; i++) begin
          m_shadow[i] = '0;
          m_active[i] = '0;
        end
      end else begin
        commit = running && (pos == FRAME - 1);
        if (commit) m_active = m_shadow;
        if (wr_if.wr_valid && rdy && (int'(wr_if.wr_digit) < NDIG))
          m_shadow[wr_if.wr_digit] = wr_if.wr_data;
        if (!en) running = 0;
        else if (!running) begin
          running = 1;
          pos     = 0;
        end else pos = (pos + 1) % FRAME;
        e.fd = commit;
        if (running) begin
          dig   = pos / SLOT;
          e.cur = 3'(dig);
          if (pos % SLOT >= BC) begin
            e.an = ~(8'd1 << dig);
            hi = 0;
            for (int i = 0; i < NDIG; i++) if (m_active[i] != 5'd0) hi = i;
            if (!(lz_blank_en && dig > hi)) begin
              e.seg = ~hex_tab[m_active[dig][3:0]];
              e.dp  = ~m_active[dig][4];
            end
          end
        end
        rdy   = !(running && pos == FRAME - 1);
        e.rdy = rdy;
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {an, seg, dp, cur_digit, frame_done, wr_if.wr_ready};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t: got an=%h seg=%h dp=%b cur=%0d fd=%b rdy=%b, want an=%h seg=%h dp=%b cur=%0d fd=%b rdy=%b",
                   $time, a.an, a.seg, a.dp, a.cur, a.fd, a.rdy, e.an, e.seg, e.dp, e.cur, e.fd, e.rdy);
        end
      end
    end
  end

  // Write source: holds each offer until it sees it accepted, as a valid/ready master must.
  initial begin : writer
    bit rdy_seen;
    rdy_seen = 0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_digit = 3'd0;
    wr_if.wr_data  = 5'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_if.wr_valid = 1'b0;
        rdy_seen = 0;
      end else begin
        if (wr_if.wr_valid && rdy_seen) wr_if.wr_valid = 1'b0;
        if (!wr_if.wr_valid) begin
          if (wr_q.size() > 0) begin
            {wr_if.wr_digit, wr_if.wr_data} = wr_q.pop_front();
            wr_if.wr_valid = 1'b1;
          end else if (rand_pct > 0 && $urandom_range(99) < rand_pct) begin
            wr_if.wr_digit = 3'($urandom_range(7));
            wr_if.wr_data  = 5'($urandom);
            wr_if.wr_valid = 1'b1;
          end
        end
        rdy_seen = wr_if.wr_ready;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drive(input logic [2:0] d);
    int k;
    for (k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      if (cur_digit == d && an != 8'hFF) break;
    end
    if (k == 3 * FRAME) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_drive: digit %0d never driven within %0d cycles", d, 3 * FRAME);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    step(3);
    rst = 1'b0;
    step(5);

    // Free-running scan of an all-zero display.
    en = 1'b1;
    step(FRAME + 10);

    // Mid-frame writes appear only after the next commit.
    wr_q.push_back({3'd3, 5'h05});
    wr_q.push_back({3'd0, 5'h1A});
    step(2 * FRAME);

    // Continuous offers guarantee a write is pending on each commit cycle.
    rand_pct = 100;
    step(FRAME + 20);
    rand_pct = 40;
    step(2 * FRAME);
    rand_pct = 0;
    step(5);

    // Leading-zero blanking with digits 7..0 = {0,0,0,0,0,7,0,3}.
    lz_blank_en = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      logic [4:0] v;
      v = (i == 2) ? 5'h07 : (i == 0) ? 5'h03 : 5'h00;
      wr_q.push_back({3'(i), v});
    end
    step(2 * FRAME + 10);

    // Disable during digit 4 drive, then restart from digit 0.
    wait_drive(3'd4);
    step(3);
    en = 1'b0;
    step(6);
    en = 1'b1;
    step(FRAME + 10);

    // Random enable glitches with random writes.
    rand_pct = 60;
    for (int r = 0; r < 6; r++) begin
      step($urandom_range(20, 200));
      en = 1'b0;
      step($urandom_range(1, 4));
      en = 1'b1;
    end

    // Reset mid-drive with writes pending, then an all-zero display.
    lz_blank_en = 1'b0;
    rand_pct = 100;
    wait_drive(3'd5);
    step(4);
    rst = 1'b1;
    rand_pct = 0;
    wr_q.delete();
    step(3);
    rst = 1'b0;
    step(FRAME + 20);

    en = 1'b0;
    step(4);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
